pipe_reg_elastic: RTL
=====================

Name: pipe_reg_elastic

Overview:
- Parametrised, elastic pipeline register chain for the pipelined processor datapath; successor to the plain n-bit enable register.
- Moves N-bit payloads through DEPTH register stages with a valid/ready handshake, synchronous flush (bubble insertion) and an occupancy count.
- Each stage has a skid entry, so every ready is registered and full throughput is sustained under backpressure.
- Placed between processor stages (e.g. IF/ID, ID/EX) where stall and flush must be handled locally.

Parameters:
- N, 32, payload width in bits (>=1).
- DEPTH, 1, number of cascaded stages (1..8).
- RST_VAL, 0, N-bit value loaded into every data register on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately.
- flush  input  1  synchronous flush; invalidates every stage at the next edge.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  block can accept; registered, with no combinational path from out_ready.
- in_data  input  N  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts.
- out_data  output  N  downstream payload.
- count  output  CW  valid entries held, 0..2*DEPTH, where CW = clog2(2*DEPTH+1).

Behaviour:
- Reset (rst=0, asynchronous):
  - all valid bits 0, all data registers = RST_VAL.
  - out_valid=0, out_data=RST_VAL, count=0, in_ready=1 (asserted once rst is released).
  - Reset mid-transfer discards all payloads; no partial state survives.
- Handshake:
  - A transfer occurs on an edge where valid&ready=1.
  - in_data is sampled only on an accept edge.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - Upstream may deassert in_valid without a transfer; the block makes no stability requirement on its input.
- Stage structure: each stage holds a main entry and a skid entry.
  - Stage ready = NOT skid_valid, taken from a register.
  - Main empty, or main draining this edge: the incoming word goes to main.
  - Main full and not draining: the incoming word goes to skid.
  - Skid occupied and main drains: skid moves to main.
- Latency and throughput:
  - Word accepted at edge t with no stalls appears on out_data with out_valid=1 in the cycle after edge t+DEPTH-1 (DEPTH cycles of latency).
  - Sustained 1 word/cycle when out_ready=1.
- Ordering: strict FIFO; no drop or duplication except on flush or reset.
- Capacity and full:
  - Maximum 2*DEPTH words in flight.
  - At count=2*DEPTH, in_ready=0; in_valid is ignored.
- Empty: count=0 implies out_valid=0; out_data holds its last value.
- Count update:
  - count(next) = count + accept - drain.
  - Simultaneous accept and drain leaves count unchanged.
- Flush (synchronous, highest priority after reset):
  - At the edge with flush=1, all valid bits clear and count becomes 0.
  - A word accepted on the flush edge is discarded.
  - A word drained on the flush edge still counts as delivered downstream.
  - Data registers are not cleared.
  - in_ready=1 in the following cycle.
  - flush held for several cycles keeps the chain empty.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package:
  - clog2 function for CW.
  - localparam for handshake encodings, reused by other elastic blocks.
- One sub-module, pipe_skid_stage:
  - a single main+skid stage with parameters N and RST_VAL, plus flush.
  - pipe_reg_elastic instantiates DEPTH copies via generate, chaining valid/ready/data, and computes count with a summing adder.

Test Plan:
- Reset: drive rst=0 mid-stream with DEPTH=3, N=8 -> out_valid=0, out_data=RST_VAL (0x00), count=0 immediately; in_ready=1 after release.
- Streaming: DEPTH=2; in_data=0x01..0x10 on consecutive cycles with out_ready=1 -> outputs 0x01..0x10 in order, first appearing 2 cycles after its accept, no gaps, count steady at 2.
- Backpressure: DEPTH=2, out_ready=0, 6 words offered -> exactly 4 accepted, count=4, in_ready=0, out_data=first word stable. Then out_ready=1 -> all 4 delivered in order, in_ready reasserts one cycle after the first drain.
- Flush: 3 words in flight with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0; the concurrently offered word is never output.
- Simultaneous accept/drain: DEPTH=1 at count=1, out_ready=1, in_valid=1 -> count stays 1 and data advances each cycle.
- Random stress: randomised in_valid/out_ready, N=32, DEPTH=4, 10k cycles -> output matches a scoreboard FIFO, count never exceeds 8, and no combinational path from out_ready to in_ready (checked by an assertion).

Source files
------------

// File: rtl/pipe_reg_elastic_pkg.sv
// Shared definitions for the elastic pipeline blocks: handshake encodings,
// per-stage occupancy states and a width helper.
package pipe_reg_elastic_pkg;

    // {valid, ready} as seen on one side of an elastic interface
    typedef enum logic [1:0] {
        HS_IDLE  = 2'b00,
        HS_READY = 2'b01,
        HS_STALL = 2'b10,
        HS_XFER  = 2'b11
    } handshake_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_FULL  = 2'b10
    } stage_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic handshake_e hs_status(input logic valid, input logic ready);
        return handshake_e'({valid, ready});
    endfunction

endpackage

// File: rtl/pipe_reg_elastic_skid.sv
// One elastic stage: a main entry feeding downstream plus a skid entry that
// absorbs the word arriving while downstream stalls, so ready is a flop.
module pipe_skid_stage
    import pipe_reg_elastic_pkg::*;
#(
    parameter int unsigned    N       = 32,
    parameter logic [N-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [N-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] data_o,
    output logic [1:0]   occ_o
);

    stage_state_e state_q, state_d;
    logic [N-1:0] main_q, main_d;
    logic [N-1:0] skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         ready_q, ready_d;
    logic         accept;
    logic         drain;

    assign accept = (hs_status(valid_i, ready_q) == HS_XFER);
    assign drain  = (hs_status(main_valid_q, ready_i) == HS_XFER);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Flush drops occupancy only; payload registers keep their contents.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = data_i;
                        state_d = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (drain) begin
                        if (accept) begin
                            main_d = data_i;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else if (accept) begin
                        skid_d  = data_i;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // ready_q is low here, so nothing can be accepted
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_MAIN;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_valid_d = (state_d != ST_EMPTY);
    assign ready_d      = (state_d != ST_FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_EMPTY;
            main_q       <= RST_VAL;
            skid_q       <= RST_VAL;
            main_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            ready_q      <= ready_d;
        end
    end

    always_comb begin
        occ_o = 2'd0;
        unique case (state_q)
            ST_EMPTY: occ_o = 2'd0;
            ST_MAIN:  occ_o = 2'd1;
            ST_FULL:  occ_o = 2'd2;
            default:  occ_o = 2'd0;
        endcase
    end

    assign ready_o = ready_q;
    assign valid_o = main_valid_q;
    assign data_o  = main_q;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic register chain of DEPTH main+skid stages with flush and an
// occupancy count, used between processor pipeline stages.
module pipe_reg_elastic
    import pipe_reg_elastic_pkg::*;
#(
    parameter int unsigned  N       = 32,
    parameter int unsigned  DEPTH   = 1,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0]                   out_data,
    output logic [clog2(2*DEPTH+1)-1:0]    count
);

    localparam int unsigned CW = clog2(2*DEPTH+1);

    logic         chain_valid [DEPTH+1];
    logic         chain_ready [DEPTH+1];
    logic [N-1:0] chain_data  [DEPTH+1];
    logic [1:0]   stage_occ   [DEPTH];
    logic [CW-1:0] occ_sum;

    assign chain_valid[0]     = in_valid;
    assign chain_data[0]      = in_data;
    assign chain_ready[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_skid_stage #(
            .N       (N),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst),
            .flush_i (flush),
            .valid_i (chain_valid[g]),
            .ready_o (chain_ready[g]),
            .data_i  (chain_data[g]),
            .valid_o (chain_valid[g+1]),
            .ready_i (chain_ready[g+1]),
            .data_o  (chain_data[g+1]),
            .occ_o   (stage_occ[g])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + CW'(stage_occ[i]);
        end
    end

    assign in_ready  = chain_ready[0];
    assign out_valid = chain_valid[DEPTH];
    assign out_data  = chain_data[DEPTH];
    assign count     = occ_sum;

endmodule
